// File: rtl/can_rx_bit_destuff_if.sv
// Sample-point bus between the bit timing logic, the de-stuffer and the receive FSM.
// Carries the sampled bit stream in and the stuff flags and stuff count out.
interface can_rx_bit_destuff_if;
    logic       sample_point_i;
    logic       sampled_bit_i;
    logic       destuff_en_i;
    logic       fixed_stuff_i;
    logic       bit_de_stuff_o;
    logic       stuff_err_o;
    logic [2:0] stuff_cnt_gray_o;
    logic       stuff_parity_o;

    modport master (
        output sample_point_i,
        output sampled_bit_i,
        output destuff_en_i,
        output fixed_stuff_i,
        input  bit_de_stuff_o,
        input  stuff_err_o,
        input  stuff_cnt_gray_o,
        input  stuff_parity_o
    );

    modport slave (
        input  sample_point_i,
        input  sampled_bit_i,
        input  destuff_en_i,
        input  fixed_stuff_i,
        output bit_de_stuff_o,
        output stuff_err_o,
        output stuff_cnt_gray_o,
        output stuff_parity_o
    );
endinterface

// File: rtl/can_rx_bit_destuff.sv
// CAN receive bit de-stuffer: flags dynamic and FD fixed stuff bits at the sample point,
// reports stuff violations once per frame and exports the Gray-coded dynamic stuff count.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_RUN    | tracking bit runs, stuff bits flagged and checked
// ST_LOCKED | stuff error seen this frame; everything held until enable drops
module can_rx_bit_destuff #(
    parameter int STUFF_LEN = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    can_rx_bit_destuff_if.slave   bus
);

    localparam logic [2:0] STUFF_LEN_C = 3'(STUFF_LEN);
    localparam logic [2:0] FIXED_LAST  = 3'd4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic       prev_bit_q, prev_bit_d;
    logic [2:0] same_cnt_q, same_cnt_d;
    logic [2:0] fixed_cnt_q, fixed_cnt_d;
    logic [2:0] dyn_cnt_q, dyn_cnt_d;
    logic       stuff_err_q, stuff_err_d;

    logic       stuff_pos;
    logic       bit_differs;
    logic       accept_bit;

    // The fixed-stuff position takes precedence over a pending dynamic stuff position.
    assign stuff_pos   = bus.fixed_stuff_i ? (fixed_cnt_q == 3'd0)
                                           : (same_cnt_q == STUFF_LEN_C);
    assign bit_differs = (bus.sampled_bit_i != prev_bit_q);
    assign accept_bit  = bus.destuff_en_i & bus.sample_point_i & (state_q == ST_RUN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            prev_bit_q  <= 1'b1;
            same_cnt_q  <= 3'd0;
            fixed_cnt_q <= 3'd0;
            dyn_cnt_q   <= 3'd0;
            stuff_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_bit_q  <= prev_bit_d;
            same_cnt_q  <= same_cnt_d;
            fixed_cnt_q <= fixed_cnt_d;
            dyn_cnt_q   <= dyn_cnt_d;
            stuff_err_q <= stuff_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_bit_d  = prev_bit_q;
        same_cnt_d  = same_cnt_q;
        fixed_cnt_d = fixed_cnt_q;
        dyn_cnt_d   = dyn_cnt_q;
        stuff_err_d = 1'b0;

        if (!bus.destuff_en_i) begin
            state_d     = ST_RUN;
            prev_bit_d  = 1'b1;
            same_cnt_d  = 3'd0;
            fixed_cnt_d = 3'd0;
            dyn_cnt_d   = 3'd0;
        end else if (accept_bit) begin
            if (stuff_pos && !bit_differs) begin
                state_d     = ST_LOCKED;
                stuff_err_d = 1'b1;
            end else if (bus.fixed_stuff_i) begin
                prev_bit_d = bus.sampled_bit_i;
                if (stuff_pos) begin
                    fixed_cnt_d = 3'd1;
                end else if (fixed_cnt_q == FIXED_LAST) begin
                    fixed_cnt_d = 3'd0;
                end else begin
                    fixed_cnt_d = fixed_cnt_q + 3'd1;
                end
            end else if (stuff_pos) begin
                same_cnt_d = 3'd1;
                prev_bit_d = bus.sampled_bit_i;
                dyn_cnt_d  = dyn_cnt_q + 3'd1;
            end else if ((same_cnt_q != 3'd0) && !bit_differs) begin
                same_cnt_d = same_cnt_q + 3'd1;
            end else begin
                // First bit after enable lands here because same_cnt is still zero.
                same_cnt_d = 3'd1;
                prev_bit_d = bus.sampled_bit_i;
            end
        end
    end

    assign bus.bit_de_stuff_o   = bus.destuff_en_i & (state_q == ST_RUN) & stuff_pos;
    assign bus.stuff_err_o      = stuff_err_q;
    assign bus.stuff_cnt_gray_o = dyn_cnt_q ^ (dyn_cnt_q >> 1);
    assign bus.stuff_parity_o   = ^bus.stuff_cnt_gray_o;

endmodule

// File: tb/tb_can_rx_bit_destuff.sv
// Directed bench for the CAN receive de-stuffer with STUFF_LEN = 5.
module tb_can_rx_bit_destuff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic v;

    always #5 clk = ~clk;

    can_rx_bit_destuff_if bus();

    can_rx_bit_destuff #(.STUFF_LEN(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // One sample-point strobe, then a clear cycle; checks stuff flag and error pulse.
    task automatic sample(input logic b, input logic exp_st, input logic exp_err, input string tag);
        @(negedge clk);
        bus.sample_point_i = 1'b1;
        bus.sampled_bit_i  = b;
        #1;
        check({tag, ".stuff"}, {2'b00, bus.bit_de_stuff_o}, {2'b00, exp_st});
        @(negedge clk);
        bus.sample_point_i = 1'b0;
        #1;
        check({tag, ".err"}, {2'b00, bus.stuff_err_o}, {2'b00, exp_err});
    endtask

    task automatic check_cnt(input string tag, input logic [2:0] gray, input logic par);
        check({tag, ".gray"}, bus.stuff_cnt_gray_o, gray);
        check({tag, ".par"}, {2'b00, bus.stuff_parity_o}, {2'b00, par});
    endtask

    task automatic new_frame();
        @(negedge clk);
        bus.destuff_en_i  = 1'b0;
        bus.fixed_stuff_i = 1'b0;
        @(negedge clk);
        bus.destuff_en_i = 1'b1;
    endtask

    initial begin
        bus.sample_point_i = 1'b0;
        bus.sampled_bit_i  = 1'b1;
        bus.destuff_en_i   = 1'b0;
        bus.fixed_stuff_i  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.stuff", {2'b00, bus.bit_de_stuff_o}, 3'b000);
        check("rst.err", {2'b00, bus.stuff_err_o}, 3'b000);
        check_cnt("rst", 3'b000, 1'b0);

        // Sample points ignored while disabled
        sample(1'b1, 1'b0, 1'b0, "dis");

        // Dynamic stuff after SOF + four dominant bits
        new_frame();
        sample(1'b0, 1'b0, 1'b0, "t1.sof");
        for (int i = 0; i < 4; i++) sample(1'b0, 1'b0, 1'b0, "t1.d");
        sample(1'b1, 1'b1, 1'b0, "t1.stf");
        check_cnt("t1", 3'b001, 1'b1);
        sample(1'b1, 1'b0, 1'b0, "t1.post");

        // Sixth equal bit -> single error pulse, then lock
        new_frame();
        for (int i = 0; i < 5; i++) sample(1'b1, 1'b0, 1'b0, "t2.d");
        sample(1'b1, 1'b1, 1'b1, "t2.viol");
        @(negedge clk);
        #1;
        check("t2.pulse_end", {2'b00, bus.stuff_err_o}, 3'b000);
        for (int i = 0; i < 7; i++) sample(1'b1, 1'b0, 1'b0, "t2.lock");
        sample(1'b0, 1'b0, 1'b0, "t2.lock0");
        new_frame();
        for (int i = 0; i < 5; i++) sample(1'b1, 1'b0, 1'b0, "t2b.d");
        sample(1'b1, 1'b1, 1'b1, "t2b.viol");

        // Eight valid dynamic stuff bits: count wraps
        new_frame();
        v = 1'b0;
        for (int i = 0; i < 5; i++) sample(v, 1'b0, 1'b0, "t3.d");
        for (int k = 1; k <= 8; k++) begin
            sample(~v, 1'b1, 1'b0, "t3.stf");
            v = ~v;
            if (k == 6) check_cnt("t3.six", 3'b101, 1'b0);
            if (k == 3) check_cnt("t3.three", 3'b010, 1'b1);
            for (int i = 0; i < 4; i++) sample(v, 1'b0, 1'b0, "t3.d");
        end
        check_cnt("t3.wrap", 3'b000, 1'b0);

        // Fixed stuffing entered with three equal bits pending, dyn_cnt = 1
        new_frame();
        sample(1'b0, 1'b0, 1'b0, "t4.sof");
        for (int i = 0; i < 4; i++) sample(1'b0, 1'b0, 1'b0, "t4.d");
        sample(1'b1, 1'b1, 1'b0, "t4.dstf");
        sample(1'b1, 1'b0, 1'b0, "t4.d");
        sample(1'b1, 1'b0, 1'b0, "t4.d");
        bus.fixed_stuff_i = 1'b1;
        sample(1'b0, 1'b1, 1'b0, "t4.fs1");
        sample(1'b0, 1'b0, 1'b0, "t4.a");
        sample(1'b1, 1'b0, 1'b0, "t4.b");
        sample(1'b0, 1'b0, 1'b0, "t4.c");
        sample(1'b1, 1'b0, 1'b0, "t4.d");
        sample(1'b0, 1'b1, 1'b0, "t4.fs6");
        check_cnt("t4.hold", 3'b001, 1'b1);
        sample(1'b1, 1'b0, 1'b0, "t4.e");
        sample(1'b1, 1'b0, 1'b0, "t4.f");
        sample(1'b0, 1'b0, 1'b0, "t4.g");
        sample(1'b0, 1'b0, 1'b0, "t4.h");
        sample(1'b1, 1'b1, 1'b0, "t4.fs11");
        for (int i = 0; i < 4; i++) sample(1'b1, 1'b0, 1'b0, "t4.i");
        sample(1'b1, 1'b1, 1'b1, "t4.fviol");
        check_cnt("t4.end", 3'b001, 1'b1);

        // First fixed bit is a stuff bit even with a dynamic stuff pending
        new_frame();
        for (int i = 0; i < 5; i++) sample(1'b0, 1'b0, 1'b0, "t4b.d");
        bus.fixed_stuff_i = 1'b1;
        sample(1'b1, 1'b1, 1'b0, "t4b.fs1");
        sample(1'b1, 1'b0, 1'b0, "t4b.a");
        check_cnt("t4b", 3'b000, 1'b0);

        // Reset mid-frame with same_cnt = 4
        new_frame();
        for (int i = 0; i < 4; i++) sample(1'b0, 1'b0, 1'b0, "t5.d");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5.stuff", {2'b00, bus.bit_de_stuff_o}, 3'b000);
        check("t5.err", {2'b00, bus.stuff_err_o}, 3'b000);
        check_cnt("t5", 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) sample(1'b0, 1'b0, 1'b0, "t5.after");

        // Idle cycles with a dynamic stuff position pending
        sample(1'b0, 1'b0, 1'b0, "t6.d5");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("t6.idle", {2'b00, bus.bit_de_stuff_o}, 3'b001);
        end
        sample(1'b1, 1'b1, 1'b0, "t6.stf");
        check_cnt("t6", 3'b001, 1'b1);

        // Disable coinciding with a sample point clears state
        @(negedge clk);
        bus.destuff_en_i   = 1'b0;
        bus.sample_point_i = 1'b1;
        bus.sampled_bit_i  = 1'b1;
        @(negedge clk);
        bus.sample_point_i = 1'b0;
        #1;
        check("t7.err", {2'b00, bus.stuff_err_o}, 3'b000);
        check_cnt("t7", 3'b000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
